// File: rtl/write_back_top.sv
// ---------------------------------------------------------------------------
// write_back_top
// Final pipeline stage of the etcpu core. It extracts load bytes and
// halfwords with sign or zero extension, then commits results into the
// 32x32 architectural register file. Two combinational read ports bypass the
// value being written in the same cycle. The block also keeps a
// retired-instruction counter and a sticky misaligned/illegal load flag.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   wb_vld              wb_inst/wb_dat carry a valid instruction
//   wb_inst, wb_dat     instruction and data from the memory stage
//   wb_addr_lsb         byte offset of the load address
//   rs1_addr/rs2_addr   decode read port addresses
//   rs1_dat/rs2_dat     read port data (combinational, bypassed)
//   rd_wen/addr/dat     commit strobe, destination register and data
//   retire_cnt          count of valid instructions retired (wraps)
//   wb_err              sticky misaligned or illegal load flag
// ---------------------------------------------------------------------------
module write_back_top #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_vld,
    input  logic [31:0]      wb_inst,
    input  logic [31:0]      wb_dat,
    input  logic [1:0]       wb_addr_lsb,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [31:0]      rs1_dat,
    output logic [31:0]      rs2_dat,
    output logic             rd_wen,
    output logic [4:0]       rd_addr,
    output logic [31:0]      rd_dat,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             wb_err
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             is_load;
    logic             writes_op;
    logic             load_legal;
    logic [31:0]      shifted;
    logic [31:0]      load_dat;
    logic [31:0]      regs_q [1:31];
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             wb_err_q, wb_err_d;
    logic             unused_inst_hi;

    assign opcode         = wb_inst[6:0];
    assign rd_addr        = wb_inst[11:7];
    assign funct3         = wb_inst[14:12];
    assign unused_inst_hi = ^wb_inst[31:15];

    assign is_load = (opcode == OP_LOAD);

    always_comb begin
        writes_op = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP: writes_op = 1'b1;
            default: writes_op = 1'b0;
        endcase
    end

    // Move the addressed byte/halfword down to bit 0 before extension.
    assign shifted = wb_dat >> {wb_addr_lsb, 3'b000};

    always_comb begin
        load_legal = 1'b0;
        load_dat   = wb_dat;
        case (funct3)
            3'b000: begin
                load_legal = 1'b1;
                load_dat   = {{24{shifted[7]}}, shifted[7:0]};
            end
            3'b100: begin
                load_legal = 1'b1;
                load_dat   = {24'h0, shifted[7:0]};
            end
            3'b001: begin
                load_legal = ~wb_addr_lsb[0];
                load_dat   = {{16{shifted[15]}}, shifted[15:0]};
            end
            3'b101: begin
                load_legal = ~wb_addr_lsb[0];
                load_dat   = {16'h0, shifted[15:0]};
            end
            3'b010: begin
                load_legal = (wb_addr_lsb == 2'b00);
                load_dat   = wb_dat;
            end
            default: begin
                load_legal = 1'b0;
                load_dat   = wb_dat;
            end
        endcase
    end

    assign rd_dat = is_load ? load_dat : wb_dat;

    assign rd_wen = wb_vld & writes_op & (~is_load | load_legal)
                  & (rd_addr != 5'd0) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (rd_wen) begin
            regs_q[rd_addr] <= rd_dat;
        end
    end

    always_comb begin
        rs1_dat = 32'h0;
        if (rs1_addr != 5'd0) begin
            rs1_dat = (rd_wen && (rs1_addr == rd_addr)) ? rd_dat : regs_q[rs1_addr];
        end
    end

    always_comb begin
        rs2_dat = 32'h0;
        if (rs2_addr != 5'd0) begin
            rs2_dat = (rd_wen && (rs2_addr == rd_addr)) ? rd_dat : regs_q[rs2_addr];
        end
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        wb_err_d     = wb_err_q;
        if (wb_vld) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
            if (is_load && !load_legal) begin
                wb_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_write_back_top.sv
module tb_write_back_top;

    localparam int CNT_W = 4;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_vld;
    logic [31:0]      wb_inst;
    logic [31:0]      wb_dat;
    logic [1:0]       wb_addr_lsb;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [31:0]      rs1_dat;
    logic [31:0]      rs2_dat;
    logic             rd_wen;
    logic [4:0]       rd_addr;
    logic [31:0]      rd_dat;
    logic [CNT_W-1:0] retire_cnt;
    logic             wb_err;

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    write_back_top #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .wb_vld(wb_vld), .wb_inst(wb_inst),
        .wb_dat(wb_dat), .wb_addr_lsb(wb_addr_lsb),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_dat(rs1_dat), .rs2_dat(rs2_dat),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_dat(rd_dat),
        .retire_cnt(retire_cnt), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
        return {17'h0, f3, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs are changed 1 time unit after the edge.
    task automatic step();
        if (wb_vld && !rst) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] dat, input logic [1:0] lsb);
        wb_vld      = 1'b1;
        wb_inst     = inst;
        wb_dat      = dat;
        wb_addr_lsb = lsb;
        #1;
    endtask

    task automatic bubble();
        wb_vld = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_vld = 1'b0; wb_inst = '0; wb_dat = '0;
        wb_addr_lsb = '0; rs1_addr = '0; rs2_addr = '0;
        step(); step();

        // Instruction presented during reset is dropped and not counted
        drive(mk(OP_IMM, 5'd5, 3'b000), 32'h11111111, 2'd0);
        chk("rd_wen_in_rst", {31'h0, rd_wen}, 32'h0);
        step();
        rst = 1'b0;
        bubble();

        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            chk("reset_rs1", rs1_dat, 32'h0);
            chk("reset_rs2", rs2_dat, 32'h0);
        end
        chk("reset_cnt", {28'h0, retire_cnt}, 32'h0);
        chk("reset_err", {31'h0, wb_err}, 32'h0);

        // OP_IMM write with same-cycle bypass
        rs1_addr = 5'd5; rs2_addr = 5'd6;
        drive(mk(OP_IMM, 5'd5, 3'b000), 32'hDEADBEEF, 2'd0);
        chk("imm_wen", {31'h0, rd_wen}, 32'h1);
        chk("imm_bypass", rs1_dat, 32'hDEADBEEF);
        chk("imm_nobypass", rs2_dat, 32'h0);
        step();
        bubble();
        chk("imm_stored", rs1_dat, 32'hDEADBEEF);
        chk("imm_cnt", {28'h0, retire_cnt}, 32'd1);

        // Load extraction into x3
        rs1_addr = 5'd3;
        drive(mk(OP_LOAD, 5'd3, 3'b000), 32'h80FF7F01, 2'd3);
        chk("lb3_dat", rd_dat, 32'hFFFFFF80);
        chk("lb3_wen", {31'h0, rd_wen}, 32'h1);
        step(); bubble();
        chk("lb3_stored", rs1_dat, 32'hFFFFFF80);
        drive(mk(OP_LOAD, 5'd3, 3'b100), 32'h80FF7F01, 2'd3);
        chk("lbu3_dat", rd_dat, 32'h00000080);
        step(); bubble();
        chk("lbu3_stored", rs1_dat, 32'h00000080);
        drive(mk(OP_LOAD, 5'd3, 3'b001), 32'h80FF7F01, 2'd2);
        chk("lh2_dat", rd_dat, 32'hFFFF80FF);
        step(); bubble();
        chk("lh2_stored", rs1_dat, 32'hFFFF80FF);
        drive(mk(OP_LOAD, 5'd3, 3'b101), 32'h80FF7F01, 2'd2);
        chk("lhu2_dat", rd_dat, 32'h000080FF);
        step(); bubble();
        chk("lhu2_stored", rs1_dat, 32'h000080FF);
        drive(mk(OP_LOAD, 5'd3, 3'b000), 32'h80FF7F01, 2'd1);
        chk("lb1_dat", rd_dat, 32'h0000007F);
        drive(mk(OP_LOAD, 5'd3, 3'b001), 32'h80FF7F01, 2'd0);
        chk("lh0_dat", rd_dat, 32'h00007F01);
        drive(mk(OP_LOAD, 5'd3, 3'b010), 32'h80FF7F01, 2'd0);
        chk("lw0_dat", rd_dat, 32'h80FF7F01);
        chk("lw0_wen", {31'h0, rd_wen}, 32'h1);
        step(); bubble();
        chk("lw0_stored", rs1_dat, 32'h80FF7F01);

        // Misaligned / illegal loads
        rs1_addr = 5'd7;
        drive(mk(OP_OP, 5'd7, 3'b000), 32'h12345678, 2'd0);
        step();
        drive(mk(OP_LOAD, 5'd3, 3'b001), 32'h0, 2'd1);
        chk("lh1_wen", {31'h0, rd_wen}, 32'h0);
        drive(mk(OP_LOAD, 5'd3, 3'b011), 32'h0, 2'd0);
        chk("f3_011_wen", {31'h0, rd_wen}, 32'h0);
        drive(mk(OP_LOAD, 5'd7, 3'b010), 32'hAAAAAAAA, 2'd1);
        chk("lw1_wen", {31'h0, rd_wen}, 32'h0);
        chk("lw1_err_pre", {31'h0, wb_err}, 32'h0);
        chk("lw1_x7_pre", rs1_dat, 32'h12345678);
        step(); bubble();
        chk("lw1_err", {31'h0, wb_err}, 32'h1);
        chk("lw1_x7", rs1_dat, 32'h12345678);
        chk("lw1_cnt", {28'h0, retire_cnt}, {28'h0, exp_cnt});
        step(); step();
        chk("err_sticky", {31'h0, wb_err}, 32'h1);

        // x0 and non-writing opcode
        rs1_addr = 5'd0; rs2_addr = 5'd4;
        drive(mk(OP_IMM, 5'd0, 3'b000), 32'hFFFFFFFF, 2'd0);
        chk("x0_wen", {31'h0, rd_wen}, 32'h0);
        chk("x0_read", rs1_dat, 32'h0);
        step();
        drive(mk(OP_STORE, 5'd4, 3'b010), 32'hCAFEF00D, 2'd0);
        chk("store_wen", {31'h0, rd_wen}, 32'h0);
        step(); bubble();
        chk("x0_after", rs1_dat, 32'h0);
        chk("x4_after", rs2_dat, 32'h0);

        // Dual bypass
        rs1_addr = 5'd9; rs2_addr = 5'd9;
        drive(mk(OP_IMM, 5'd9, 3'b000), 32'hA5A5A5A5, 2'd0);
        chk("dual_rs1", rs1_dat, 32'hA5A5A5A5);
        chk("dual_rs2", rs2_dat, 32'hA5A5A5A5);
        step(); bubble();
        chk("dual_cnt", {28'h0, retire_cnt}, {28'h0, exp_cnt});

        // Counter wrap: run until the 4-bit counter returns to 0
        while (exp_cnt != '0) begin
            drive(mk(OP_STORE, 5'd1, 3'b010), 32'h0, 2'd0);
            step();
        end
        bubble();
        chk("wrap_cnt", {28'h0, retire_cnt}, 32'h0);
        step(); step(); step();
        chk("bubble_cnt", {28'h0, retire_cnt}, 32'h0);
        drive(mk(OP_STORE, 5'd1, 3'b010), 32'h0, 2'd0);
        step(); bubble();
        chk("post_wrap_cnt", {28'h0, retire_cnt}, 32'h1);

        // Reset wins over a same-edge misaligned load
        rs1_addr = 5'd5;
        rst = 1'b1;
        drive(mk(OP_LOAD, 5'd7, 3'b010), 32'h0, 2'd3);
        step();
        rst = 1'b0;
        bubble();
        exp_cnt = '0;
        chk("rst_err", {31'h0, wb_err}, 32'h0);
        chk("rst_cnt", {28'h0, retire_cnt}, 32'h0);
        chk("rst_x5", rs1_dat, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/write_back_top.md
# write_back_top

Final pipeline stage of the etcpu core, directly downstream of the memory access stage. Consumes the writeback instruction and data, performs load byte/halfword selection and sign/zero extension, and commits results into the 32x32 architectural register file. Provides two combinational read ports with same-cycle write bypass to the decode stage. Also keeps a retired-instruction counter and a sticky misaligned-load error flag.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_vld  in  1  wb_inst/wb_dat hold a valid instruction this cycle
- wb_inst  in  32  writeback instruction from memory access stage
- wb_dat  in  32  writeback data: raw memory word for OP_LOAD, ALU result otherwise
- wb_addr_lsb  in  2  byte offset of the load address (bits [1:0] of the memory address)
- rs1_addr  in  5  decode read port 1 address
- rs2_addr  in  5  decode read port 2 address
- rs1_dat  out  32  read port 1 data (combinational, bypassed)
- rs2_dat  out  32  read port 2 data (combinational, bypassed)
- rd_wen  out  1  commit strobe this cycle (combinational)
- rd_addr  out  5  destination register of current commit
- rd_dat  out  32  data being committed
- retire_cnt  out  CNT_W  count of valid instructions retired
- wb_err  out  1  sticky: misaligned or illegal-funct3 load seen

## Operation
- Opcode = wb_inst[6:0]; rd = wb_inst[11:7]; funct3 = wb_inst[14:12]; opcodes from utils_top.
- Writing opcodes: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP. All others (STORE, BRANCH, MISC-MEM, SYSTEM, unknown) never write.
- Non-load write data = wb_dat unchanged.
- Load data by funct3, byte index b = wb_addr_lsb:
  - 000 LB: sign-extend wb_dat[8b+7:8b]; 100 LBU: zero-extend same byte.
  - 001 LH / 101 LHU: halfword at wb_dat[8b+15:8b], sign/zero-extend; legal only for b in {0,2}.
  - 010 LW: wb_dat; legal only for b=0.
  - 011, 110, 111: illegal.
- Illegal or misaligned load: no register write, wb_err set on next edge (when wb_vld=1).
- rd_wen = wb_vld & writing opcode & legal & rd!=0 & !rst. rd_addr/rd_dat reflect current decode even when rd_wen=0.
- Register file: x0 never written, always reads 0. Write of rd_dat into reg[rd_addr] on edge where rd_wen=1.
- Read ports: addr 0 -> 0; else if rd_wen and addr==rd_addr -> rd_dat (bypass); else stored value. Both ports may bypass simultaneously.
- retire_cnt increments by 1 on each edge with wb_vld=1 (writing or not, including illegal loads); wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (rst=1 at edge): all 31 registers, retire_cnt, wb_err cleared to 0; write in that cycle suppressed; rd_wen=0 while rst=1.
- Commit latency: value visible in stored file one edge after rd_wen; visible on read ports same cycle via bypass.
- No stall/handshake: stage accepts every cycle; wb_vld=0 is a bubble (no write, no count).
- wb_err: set on edge with illegal/misaligned valid load, held until rst; set and reset same edge -> reset wins.
- Reset mid-stream: instruction presented during rst is dropped and not counted.
- Outputs rs1_dat/rs2_dat/rd_* purely combinational; retire_cnt, wb_err registered.

## Test plan
- Reset, then read all 32 addresses -> all 0; retire_cnt=0, wb_err=0.
- OP_IMM rd=5, wb_dat=0xDEADBEEF, rs1_addr=5 same cycle -> rs1_dat=0xDEADBEEF (bypass), next cycle stored value 0xDEADBEEF; retire_cnt=1.
- LB rd=3, wb_dat=0x80FF7F01, lsb=3 -> x3=0xFFFFFF80; LBU lsb=3 -> 0x00000080; LH lsb=2 -> 0xFFFF80FF; LHU lsb=2 -> 0x000080FF.
- LW lsb=1 rd=7 with x7=0x12345678 -> x7 unchanged, wb_err=1 next cycle and remains 1 until rst; retire_cnt increments.
- Write rd=0 wb_dat=0xFFFFFFFF, STORE with rd field=4 -> x0 and x4 remain 0; rd_wen=0 both cycles.
- Preload retire_cnt path with CNT_W=4, 16 valid instructions -> counter wraps to 0; bubble cycles leave it unchanged.
